// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared constants for the issue-side register scoreboard.
//   NREG      : number of architectural registers tracked (R0-R15)
//   CNT_W     : width of each per-register in-flight write counter
//   REG_IDX_W : width of a register index
//   INFL_W    : width of the total in-flight write count
//   CNT_MAX   : saturation value of a per-register counter
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int NREG      = 16;
    localparam int CNT_W     = 2;
    localparam int REG_IDX_W = 4;
    localparam int INFL_W    = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_counter.sv
// -----------------------------------------------------------------------------
// scoreboard_counter
// One saturating up/down counter holding the number of outstanding writes
// to a single architectural register.
// Ports:
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low reset, clears the count
//   inc_i  : an accepted write to this register issued this cycle
//   dec_i  : WB writes this register this cycle
//   busy_o : count is non-zero
//   ovf_o  : increment refused this cycle because the count is saturated
//   udf_o  : decrement refused this cycle because the count is zero
// -----------------------------------------------------------------------------
module scoreboard_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o,
    output logic ovf_o,
    output logic udf_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A simultaneous inc and dec cancel out before any limit is checked, so
    // an issue and a retire of the same register never raise an error even
    // when the count sits at zero or at saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        udf_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == CNT_MAX) begin
                    ovf_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt_q == '0) begin
                    udf_o = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule : scoreboard_counter

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Issue-side register scoreboard for the 5-stage pipeline. Destination
// registers are recorded when an instruction issues from ID to EXE and
// released when WB writes them; the ID-stage source query is answered from
// this tracked state with a stall signal.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   issue_valid     : ID instruction requests to issue this cycle
//   issue_wb_en     : issuing instruction writes a register
//   issue_dst       : destination register of the issuing instruction
//   wb_valid        : WB writes the register file this cycle
//   wb_dst          : register written by WB
//   has_src1        : ID instruction reads src1
//   two_src         : ID instruction reads src2
//   src1, src2      : source registers of the ID instruction
//   hazard          : stall ID/IF this cycle
//   issue_ack       : issue accepted this cycle
//   busy            : per-register pending bit
//   inflight        : total accepted-but-unretired writes
//   err_ovf         : sticky, an issue hit a saturated counter
//   err_udf         : sticky, a retire hit a zero counter
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_wb_en,
    input  logic [REG_IDX_W-1:0] issue_dst,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic                 has_src1,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    output logic                 hazard,
    output logic                 issue_ack,
    output logic [NREG-1:0]      busy,
    output logic [INFL_W-1:0]    inflight,
    output logic                 err_ovf,
    output logic                 err_udf
);

    logic            issueWrite;
    logic [NREG-1:0] incVec;
    logic [NREG-1:0] decVec;
    logic [NREG-1:0] ovfVec;
    logic [NREG-1:0] udfVec;
    logic            incApplied;
    logic            decApplied;

    logic [INFL_W-1:0] inflight_q;
    logic [INFL_W-1:0] inflight_d;
    logic              err_ovf_q;
    logic              err_ovf_d;
    logic              err_udf_q;
    logic              err_udf_d;

    // The query only looks at registered counts; a retire in this same cycle
    // releases the stall one cycle later.
    assign hazard     = (has_src1 & busy[src1]) | (two_src & busy[src2]);
    assign issue_ack  = issue_valid & ~hazard;
    assign issueWrite = issue_ack & issue_wb_en;

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_cnt
            assign incVec[g] = issueWrite & (issue_dst == REG_IDX_W'(g));
            assign decVec[g] = wb_valid   & (wb_dst    == REG_IDX_W'(g));

            scoreboard_counter u_cnt (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc_i  (incVec[g]),
                .dec_i  (decVec[g]),
                .busy_o (busy[g]),
                .ovf_o  (ovfVec[g]),
                .udf_o  (udfVec[g])
            );
        end
    endgenerate

    // The total follows exactly what the counters accept: a refused increment
    // or decrement leaves it alone, and a same-register inc/dec pair nets out.
    assign incApplied = issueWrite & ~ovfVec[issue_dst];
    assign decApplied = wb_valid   & ~udfVec[wb_dst];

    always_comb begin
        inflight_d = inflight_q;
        case ({incApplied, decApplied})
            2'b10:   inflight_d = inflight_q + INFL_W'(1);
            2'b01:   inflight_d = inflight_q - INFL_W'(1);
            default: inflight_d = inflight_q;
        endcase
        err_ovf_d = err_ovf_q | (|ovfVec);
        err_udf_d = err_udf_q | (|udfVec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
        end
    end

    assign inflight = inflight_q;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed bench for reg_scoreboard. Each stimulus step drives the inputs
// just after a rising edge and queues the hand-computed outputs expected for
// that cycle; a monitor pops the queue on every falling edge and compares.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dst;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic        has_src1;
    logic        two_src;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard;
    logic        issue_ack;
    logic [15:0] busy;
    logic [3:0]  inflight;
    logic        err_ovf;
    logic        err_udf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        haz;
        logic        ack;
        logic [15:0] busy;
        logic [3:0]  infl;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_wb_en (issue_wb_en),
        .issue_dst   (issue_dst),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .has_src1    (has_src1),
        .two_src     (two_src),
        .src1        (src1),
        .src2        (src2),
        .hazard      (hazard),
        .issue_ack   (issue_ack),
        .busy        (busy),
        .inflight    (inflight),
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
    );

    // Compare one output field and record the result.
    task automatic compareField(input string nm, input string fld,
                                input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, expv);
        end
    endtask

    // Compare every DUT output against one queued expectation.
    task automatic checkOutput(input exp_t e);
        compareField(e.name, "hazard",    16'(hazard),    16'(e.haz));
        compareField(e.name, "issue_ack", 16'(issue_ack), 16'(e.ack));
        compareField(e.name, "busy",      busy,           e.busy);
        compareField(e.name, "inflight",  16'(inflight),  16'(e.infl));
        compareField(e.name, "err_ovf",   16'(err_ovf),   16'(e.ovf));
        compareField(e.name, "err_udf",   16'(err_udf),   16'(e.udf));
    endtask

    // Queue what the DUT should present for the inputs just applied.
    task automatic pushExpect(input string nm, input logic eh, input logic ea,
                              input logic [15:0] eb, input logic [3:0] ei,
                              input logic eo, input logic eu);
        exp_t e;
        e.name = nm;
        e.haz  = eh;
        e.ack  = ea;
        e.busy = eb;
        e.infl = ei;
        e.ovf  = eo;
        e.udf  = eu;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs shortly after the rising edge and queue the
    // expected outputs for that cycle.
    task automatic applyStimulus(input logic iv, input logic wbe, input logic [3:0] idst,
                                 input logic wv, input logic [3:0] wdst,
                                 input logic hs1, input logic ts,
                                 input logic [3:0] s1, input logic [3:0] s2,
                                 input string nm, input logic eh, input logic ea,
                                 input logic [15:0] eb, input logic [3:0] ei,
                                 input logic eo, input logic eu);
        @(posedge clk);
        #1;
        issue_valid = iv;
        issue_wb_en = wbe;
        issue_dst   = idst;
        wb_valid    = wv;
        wb_dst      = wdst;
        has_src1    = hs1;
        two_src     = ts;
        src1        = s1;
        src2        = s2;
        pushExpect(nm, eh, ea, eb, ei, eo, eu);
    endtask

    // Monitor: one queued expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput(monExp);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_wb_en = 1'b0;
        issue_dst   = 4'd0;
        wb_valid    = 1'b0;
        wb_dst      = 4'd0;
        has_src1    = 1'b0;
        two_src     = 1'b0;
        src1        = 4'd0;
        src2        = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        //            iv wbe idst wv wdst hs1 ts s1 s2  name                hz ak busy      inf ovf udf
        applyStimulus(0, 0, 0,   0, 0,   0, 0, 0, 0,  "idle_after_reset",  0, 0, 16'h0000, 0, 0, 0);
        applyStimulus(1, 1, 3,   0, 0,   0, 0, 0, 0,  "issue_r3",          0, 1, 16'h0000, 0, 0, 0);
        applyStimulus(1, 1, 4,   0, 0,   1, 0, 3, 0,  "raw_stall",         1, 0, 16'h0008, 1, 0, 0);
        applyStimulus(1, 1, 4,   0, 0,   1, 0, 3, 0,  "raw_hold",          1, 0, 16'h0008, 1, 0, 0);
        applyStimulus(1, 1, 4,   1, 3,   1, 0, 3, 0,  "wb_no_bypass",      1, 0, 16'h0008, 1, 0, 0);
        applyStimulus(0, 0, 0,   0, 0,   1, 0, 3, 0,  "raw_release",       0, 0, 16'h0000, 0, 0, 0);
        applyStimulus(1, 1, 5,   0, 0,   0, 0, 0, 0,  "issue_r5",          0, 1, 16'h0000, 0, 0, 0);
        applyStimulus(0, 0, 0,   0, 0,   0, 0, 5, 5,  "src_gated",         0, 0, 16'h0020, 1, 0, 0);
        applyStimulus(0, 0, 0,   0, 0,   0, 1, 0, 5,  "src2_used",         1, 0, 16'h0020, 1, 0, 0);
        applyStimulus(0, 0, 0,   1, 5,   0, 0, 0, 0,  "wb_r5",             0, 0, 16'h0020, 1, 0, 0);
        applyStimulus(1, 1, 7,   0, 0,   0, 0, 0, 0,  "r7_issue1",         0, 1, 16'h0000, 0, 0, 0);
        applyStimulus(1, 1, 7,   0, 0,   0, 0, 0, 0,  "r7_issue2",         0, 1, 16'h0080, 1, 0, 0);
        applyStimulus(1, 1, 7,   0, 0,   0, 0, 0, 0,  "r7_issue3",         0, 1, 16'h0080, 2, 0, 0);
        applyStimulus(1, 1, 7,   0, 0,   0, 0, 0, 0,  "r7_issue4_ovf",     0, 1, 16'h0080, 3, 0, 0);
        applyStimulus(0, 0, 0,   1, 7,   0, 0, 0, 0,  "r7_wb1",            0, 0, 16'h0080, 3, 1, 0);
        applyStimulus(0, 0, 0,   1, 7,   0, 0, 0, 0,  "r7_wb2",            0, 0, 16'h0080, 2, 1, 0);
        applyStimulus(0, 0, 0,   1, 7,   0, 0, 0, 0,  "r7_wb3",            0, 0, 16'h0080, 1, 1, 0);
        applyStimulus(1, 1, 2,   0, 0,   0, 0, 0, 0,  "issue_r2",          0, 1, 16'h0000, 0, 1, 0);
        applyStimulus(1, 1, 2,   1, 2,   0, 0, 0, 0,  "r2_inc_dec",        0, 1, 16'h0004, 1, 1, 0);
        applyStimulus(0, 0, 0,   1, 2,   0, 0, 0, 0,  "r2_wb",             0, 0, 16'h0004, 1, 1, 0);
        applyStimulus(1, 1, 2,   1, 2,   0, 0, 0, 0,  "r2_inc_dec_zero",   0, 1, 16'h0000, 0, 1, 0);
        applyStimulus(0, 0, 0,   1, 9,   0, 0, 0, 0,  "wb_r9_udf",         0, 0, 16'h0000, 0, 1, 0);
        applyStimulus(1, 0, 6,   0, 0,   0, 0, 0, 0,  "nowrite_issue",     0, 1, 16'h0000, 0, 1, 1);
        applyStimulus(1, 1, 15,  0, 0,   0, 0, 0, 0,  "issue_r15",         0, 1, 16'h0000, 0, 1, 1);
        applyStimulus(1, 1, 1,   1, 15,  1, 1, 15, 0, "r15_stall_wb",      1, 0, 16'h8000, 1, 1, 1);
        applyStimulus(1, 1, 3,   0, 0,   1, 0, 15, 0, "issue_r3_a",        0, 1, 16'h0000, 0, 1, 1);
        applyStimulus(1, 1, 3,   0, 0,   1, 0, 15, 0, "issue_r3_b",        0, 1, 16'h0008, 1, 1, 1);
        applyStimulus(0, 0, 0,   0, 0,   1, 0, 3, 0,  "r3_count2",         1, 0, 16'h0008, 2, 1, 1);

        // Reset asserted mid-cycle with two writes pending on R3; outputs
        // must clear before the next rising edge.
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_wb_en = 1'b0;
        wb_valid    = 1'b0;
        has_src1    = 1'b1;
        src1        = 4'd3;
        pushExpect("async_reset", 0, 0, 16'h0000, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(0, 0, 0,   0, 0,   1, 0, 3, 0,  "post_reset_idle",   0, 0, 16'h0000, 0, 0, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain: %0d left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_scoreboard

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side register scoreboard for the 5-stage ARM pipeline, used as an alternative to the comparator-based hazard check.
- Records destination registers when an instruction issues from ID to EXE, and clears them on writeback.
- Answers the ID-stage source query with a stall signal, so the stall decision comes from tracked state rather than from pipeline-register comparisons.
- Sits beside the ID stage; the issue port is driven from ID outputs and the retire port from the WB stage.

Parameters:
- NREG, 16, number of architectural registers tracked (R0-R15).
- CNT_W, 2, width of each per-register in-flight counter (max 3 outstanding writes per register).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  ID instruction is requesting to issue this cycle
- issue_wb_en  in  1  issuing instruction writes a register
- issue_dst  in  4  destination register of the issuing instruction
- wb_valid  in  1  WB stage writes the register file this cycle
- wb_dst  in  4  register written by WB
- has_src1  in  1  ID instruction reads src1
- two_src  in  1  ID instruction reads src2
- src1  in  4  first source register
- src2  in  4  second source register
- hazard  out  1  stall ID/IF this cycle
- issue_ack  out  1  issue accepted (issue_valid & ~hazard)
- busy  out  NREG  per-register pending bit (counter != 0)
- inflight  out  4  total accepted-but-unretired writes
- err_ovf  out  1  sticky: issue to a saturated counter
- err_udf  out  1  sticky: retire of a register with zero count

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0: all counters=0, inflight=0, err_ovf=0, err_udf=0. Combinationally, busy=0 and hazard=0.
- hazard is combinational from registered state only: (has_src1 & busy[src1]) | (two_src & busy[src2]). There is no bypass from a same-cycle wb_valid; the cleared counter is visible the next cycle.
- issue_ack = issue_valid & ~hazard, combinational. Only an acked issue with issue_wb_en=1 increments cnt[issue_dst] at the next clk edge. An acked issue with issue_wb_en=0 changes no state.
- wb_valid decrements cnt[wb_dst] at the next clk edge.
- Simultaneous increment and decrement of the same register: counter unchanged; no error flags.
- Increment with counter == 2^CNT_W-1 and no same-register decrement: counter holds, err_ovf sets.
- Decrement with counter == 0 and no same-register increment: counter holds at 0, err_udf sets.
- Same-register increment plus decrement when counter is 0: net unchanged (0), err_udf does not set.
- inflight tracks +1 per acked write-issue and -1 per wb_valid, with matching hold rules (no change on err cases); latency 1 cycle.
- Error flags are sticky until reset.
- Reset mid-operation discards all pending state. Pipeline flush on reset is assumed to be system-wide.
- Latency: a write issued in cycle N is visible in hazard from cycle N+1. A WB in cycle N releases the stall from cycle N+1.
- R15 is tracked like any other register. There is no special case.

Decomposition:
- Shared package: NREG, CNT_W, the REG_IDX_W=4 register-index width, and the saturation constant CNT_MAX.
- One natural sub-module: scoreboard_counter, a single saturating up/down counter with inc, dec, ovf and udf outputs.
- The top generates NREG instances of scoreboard_counter plus the query, ack and inflight logic.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with cnt[3]=2 -> busy=0, hazard=0, inflight=0 immediately, without waiting for clk.
- RAW stall: issue dst=R3 (ack=1) in cycle 0; cycle 1 with has_src1=1, src1=3 -> hazard=1, issue_ack=0; wb_valid, wb_dst=3 in cycle 3 -> hazard=0 in cycle 4.
- Src2 gating: busy[5]=1, src2=5, two_src=0 -> hazard=0; two_src=1 -> hazard=1.
- Multiple outstanding: 3 issues to R7 -> cnt=3, inflight=3; a 4th issue -> err_ovf=1, cnt stays 3; 3 WBs to R7 -> busy[7]=0, inflight=0.
- Simultaneous issue and WB: issue dst=R2 and wb_dst=R2 in the same cycle with cnt[2]=1 -> cnt[2] stays 1, no error. Same case with cnt[2]=0 -> stays 0, err_udf=0.
- Underflow and no-write issue: wb_valid to R9 with cnt[9]=0 -> err_udf=1, sticky. Acked issue with issue_wb_en=0 -> busy and inflight unchanged.
